pc_redirect_ctrl: RTL
=====================

Name: pc_redirect_ctrl

Overview:
Fetch-stage sequencer that owns the F-stage PC register and drives the next-PC selection for the P7 pipeline.
It arbitrates four redirect sources: exception entry, eret, D-stage jump/branch, and sequential PC+4.
It applies them under hazard stalls and the instruction-memory ready handshake.
A redirect that cannot be taken immediately is held in a pending latch and applied exactly once.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_4180, exception/interrupt entry address.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
req  in  1  exception/interrupt request from CP0; takes effect this cycle.
eret  in  1  eret resolved in D.
eret_target  in  32  return address supplied by CP0 (EPC).
br_taken  in  1  D-stage branch taken.
br_target  in  32  branch target.
jmp_valid  in  1  D-stage j/jal/jr/jalr.
jmp_target  in  32  jump target (imm or register).
stall  in  1  hazard-unit stall of F/D.
imem_ready  in  1  instruction memory accepts pc_f this cycle.
pc_f  out  32  current fetch address.
fetch_valid  out  1  pc_f is a real fetch (low in reset hold).
flush_d  out  1  one-cycle pulse: squash instruction entering D.
pending  out  1  a redirect is latched and waiting for imem_ready.
adel_f  out  1  pc_f[1:0] != 0 or pc_f outside 0x3000–0x6FFF.

Behaviour:
- Reset (reset low, async): pc_f=RESET_PC, pending=0, flush_d=0, fetch_valid=0. fetch_valid goes to 1 on the first clk edge after reset deasserts.
- States: RUN, PEND.
- Redirect source priority: req > eret > jmp_valid > br_taken.
- jmp_valid and br_taken are ignored while stall=1, because the D instruction is not resolved.
- req and eret are honoured regardless of stall.
- advance = imem_ready & (~stall | req | eret).
- RUN, advance=1:
  - pc_f <= the highest-priority redirect target, else pc_f+4.
  - Stay in RUN.
- RUN, advance=0 with a valid redirect present:
  - Latch the target into pend_pc and record its kind.
  - Go to PEND.
  - pc_f holds, so the address stays stable during the handshake.
- RUN, advance=0 with no redirect: pc_f holds.
- PEND:
  - A new req or eret overwrites pend_pc. Priority compares with the latched kind, so a branch never overwrites a latched req.
  - On imem_ready: pc_f <= pend_pc, go to RUN, pending deasserts in the same edge.
  - stall does not block applying a latched req/eret.
  - A latched branch/jump waits for ~stall & imem_ready.
- Delay slot: a branch/jump never asserts flush_d; the instruction at pc_f completes as the delay slot.
- flush_d is registered. It is high for exactly one cycle after a req or eret is accepted or latched. It is not pulsed again when a latched redirect is applied.
- Latency: a redirect accepted at edge N is visible on pc_f after edge N.
- pc_f+4 wraps modulo 2^32. Wrap is not special-cased; adel_f flags it.
- adel_f is combinational from pc_f. pc_f is not modified on error; CP0 raises req.
- Simultaneous req and br_taken: req wins and the branch is dropped.
- Reset asserted in PEND: the pending redirect is discarded.

Decomposition:
- Shared package pc_pkg:
  - RESET_PC and EXC_VECTOR defaults.
  - Text-segment bounds 0x3000/0x6FFF.
  - Redirect-kind enum: NONE, BR, JMP, ERET, EXC.
  - State enum: RUN, PEND.
- One sub-module, pc_redirect_arb: combinational priority encoder producing {valid, kind, target}, reused by RUN and PEND.

Test Plan:
- Reset and sequential fetch:
  - reset low mid-run → pc_f=0x3000 immediately.
  - Release reset, imem_ready=1 → pc_f is 0x3004, 0x3008 on the next two edges; fetch_valid=1 after the first edge.
- Branch under stall:
  - pc_f=0x3010, br_taken=1, br_target=0x3100, stall=1 for 2 cycles → pc_f holds 0x3010.
  - stall drops → pc_f=0x3100 next edge; flush_d stays 0.
- Pending redirect:
  - pc_f=0x3020, jmp_valid=1, jmp_target=0x3400, imem_ready=0 for 3 cycles → pending=1, pc_f=0x3020.
  - imem_ready=1 → pc_f=0x3400, pending=0.
- Exception overrides pending:
  - While a branch to 0x3100 is latched, req=1 → flush_d pulses once.
  - On imem_ready → pc_f=0x4180, not 0x3100.
- eret with stall:
  - eret=1, eret_target=0x3058, stall=1, imem_ready=1 → pc_f=0x3058 next edge; flush_d=1 for one cycle.
- Simultaneous events and address error:
  - req+br_taken in the same cycle → pc_f=0x4180.
  - Jump to 0x3002 → adel_f=1 while pc_f=0x3002.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Redirect kinds are ordered so a larger code means higher priority.
package pc_pkg;

  localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO        = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI        = 32'h0000_6FFF;

  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_BR   = 3'd1,
    K_JMP  = 3'd2,
    K_ERET = 3'd3,
    K_EXC  = 3'd4
  } redir_kind_e;

  typedef logic [0:0] pc_state_t;

  localparam pc_state_t ST_RUN  = 1'b0;
  localparam pc_state_t ST_PEND = 1'b1;

  typedef struct packed {
    logic        valid;
    redir_kind_e kind;
    logic [31:0] target;
  } redir_t;

  function automatic logic is_trap(
    input redir_kind_e k
  );
    return (k == K_EXC) || (k == K_ERET);
  endfunction

  function automatic logic addr_err(
    input logic [31:0] a
  );
    return (a[1:0] != 2'b00) ||
           (a < TEXT_LO) ||
           (a > TEXT_HI);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority encoder over the four redirect sources.
// Branch/jump are masked by stall because D is not resolved yet.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] eret_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        stall,
  output redir_t      redir
);

  logic sel_exc;
  logic sel_eret;
  logic sel_jmp;
  logic sel_br;

  assign sel_exc  = req;
  assign sel_eret = eret & ~req;
  assign sel_jmp  = jmp_valid & ~stall & ~req & ~eret;
  assign sel_br   = br_taken & ~stall & ~req & ~eret
                  & ~jmp_valid;

  always_comb begin
    redir = '0;
    unique case (1'b1)
      sel_exc: begin
        redir.valid  = 1'b1;
        redir.kind   = K_EXC;
        redir.target = EXC_VECTOR;
      end
      sel_eret: begin
        redir.valid  = 1'b1;
        redir.kind   = K_ERET;
        redir.target = eret_target;
      end
      sel_jmp: begin
        redir.valid  = 1'b1;
        redir.kind   = K_JMP;
        redir.target = jmp_target;
      end
      sel_br: begin
        redir.valid  = 1'b1;
        redir.kind   = K_BR;
        redir.target = br_target;
      end
      default: redir = '0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// F-stage PC register with redirect arbitration, stall and imem handshake.
// Redirects that miss the handshake are parked and applied exactly once.
module pc_redirect_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = PC_RESET_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] eret_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [31:0] pc_f,
  output logic        fetch_valid,
  output logic        flush_d,
  output logic        pending,
  output logic        adel_f
);

  redir_t      arb;
  pc_state_t   state_q;
  pc_state_t   state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pend_pc_q;
  logic [31:0] pend_pc_d;
  redir_kind_e pend_kind_q;
  redir_kind_e pend_kind_d;
  logic        flush_q;
  logic        flush_nx;
  logic        fv_q;

  logic        advance;
  logic        new_trap;
  logic        ovr;
  redir_kind_e eff_kind;
  logic [31:0] eff_pc;
  logic        apply;

  pc_redirect_arb #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .req         (req),
    .eret        (eret),
    .eret_target (eret_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .stall       (stall),
    .redir       (arb)
  );

  assign advance  = imem_ready & (~stall | req | eret);
  assign new_trap = arb.valid & is_trap(arb.kind);

  // Only traps may replace a parked redirect, and never a stronger one.
  assign ovr      = new_trap & (arb.kind >= pend_kind_q);
  assign eff_kind = ovr ? arb.kind : pend_kind_q;
  assign eff_pc   = ovr ? arb.target : pend_pc_q;
  assign apply    = imem_ready & (is_trap(eff_kind) | ~stall);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_kind_d = pend_kind_q;
    flush_nx    = 1'b0;
    case (state_q)
      ST_RUN: begin
        flush_nx = new_trap;
        if (advance) begin
          pc_d = arb.valid ? arb.target
                           : pc_q + 32'd4;
        end else if (arb.valid) begin
          state_d     = ST_PEND;
          pend_pc_d   = arb.target;
          pend_kind_d = arb.kind;
        end
      end
      ST_PEND: begin
        flush_nx = ovr;
        if (apply) begin
          state_d     = ST_RUN;
          pc_d        = eff_pc;
          pend_kind_d = K_NONE;
        end else begin
          pend_pc_d   = eff_pc;
          pend_kind_d = eff_kind;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      pend_kind_q <= K_NONE;
      flush_q     <= 1'b0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_kind_q <= pend_kind_d;
      flush_q     <= flush_nx;
      fv_q        <= 1'b1;
    end
  end

  assign pc_f        = pc_q;
  assign fetch_valid = fv_q;
  assign flush_d     = flush_q;
  assign pending     = (state_q == ST_PEND);
  assign adel_f      = addr_err(pc_q);

endmodule
